// File: rtl/tick_enable_generator.sv
// Multi-channel clock-enable generator: programmable single-cycle ticks per channel,
// gated by a filtered PLL-lock qualifier and realignable with a resync strobe.
module tick_enable_generator #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 24,
  parameter int LOCK_FILTER = 8,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {24'd1, 24'd2, 24'd75000, 24'd75},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              resync,
  output logic              ready,
  output logic [NUM_CH-1:0] tick
);

  localparam int FCNT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(LOCK_FILTER - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_FILTER = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  logic              sync1_q;
  logic              sync2_q;
  logic              lock_s;
  state_e            state_q;
  state_e            state_d;
  logic [FCNT_W-1:0] fcnt_q;
  logic [FCNT_W-1:0] fcnt_d;
  logic              ready_q;
  logic              ready_d;

  logic [DIV_W-1:0]  div_q  [NUM_CH];
  logic [DIV_W-1:0]  div_d  [NUM_CH];
  logic [DIV_W-1:0]  cnt_q  [NUM_CH];
  logic [DIV_W-1:0]  cnt_d  [NUM_CH];
  logic [DIV_W-1:0]  per_s  [NUM_CH];
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;
  logic              active_s;
  logic              cfg_hit_s;

  // pll_locked is asynchronous to clk; two flops before anything looks at it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign lock_s = sync2_q;

  // Qualifier state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      fcnt_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ready_q <= ready_d;
    end
  end

  // Qualifier next-state logic
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_FILTER;
          fcnt_d  = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FILTER: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (fcnt_q == FILT_LAST) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_WAIT;
        fcnt_d  = '0;
      end
    endcase
  end

  // ready tracks the state being entered so it moves on the same edge
  always_comb begin
    ready_d = (state_d == ST_RUN);
  end

  assign active_s  = (state_q == ST_RUN) && lock_s;
  assign cfg_hit_s = cfg_we && (int'(cfg_ch) < NUM_CH);

  // Per-channel divisor, counter and tick next-state, highest priority first
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      per_s[i]  = (div_q[i] == '0) ? DIV_W'(1) : div_q[i];
      div_d[i]  = div_q[i];
      cnt_d[i]  = cnt_q[i];
      tick_d[i] = 1'b0;
      if (cfg_hit_s && (cfg_ch == CH_W'(i))) begin
        div_d[i] = cfg_div;
      end else begin
        div_d[i] = div_q[i];
      end
      if (!active_s) begin
        cnt_d[i] = '0;
      end else if (resync) begin
        cnt_d[i] = '0;
      end else if (cfg_hit_s && (cfg_ch == CH_W'(i))) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= per_s[i] - DIV_W'(1)) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end
    end
  end

  // Channel registers; divisors only return to their defaults on rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_INIT[i*DIV_W +: DIV_W];
        cnt_q[i] <= '0;
      end
      tick_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      tick_q <= tick_d;
    end
  end

  assign ready = ready_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_tick_enable_generator.sv
// Randomised bench for tick_enable_generator against an edge-indexed reference model
// (lock streak length and tick phase as distance from the last channel restart).
module tb_tick_enable_generator;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 24;
  localparam int LF     = 8;
  localparam int CH_W   = 2;

  logic              clk;
  logic              rst_n;
  logic              pll_locked;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic              resync;
  logic              ready;
  logic [NUM_CH-1:0] tick;

  int total_cnt = 0;
  int bad_cnt   = 0;

  tick_enable_generator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .resync     (resync),
    .ready      (ready),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int   edge_n;
  int   hist [2];
  int   streak;
  bit   m_ready;
  bit   m_tick [NUM_CH];
  int   m_div  [NUM_CH];
  int   origin [NUM_CH];
  int   init_div [NUM_CH] = '{75, 75000, 2, 1};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    edge_n  = 0;
    hist[0] = 0;
    hist[1] = 0;
    streak  = 0;
    m_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_tick[i] = 1'b0;
      m_div[i]  = init_div[i];
      origin[i] = 0;
    end
  endfunction

  // Predict outputs after the next edge from the inputs applied before it
  function automatic void model_edge(input bit pl, input bit we, input int ch, input int dv, input bit rs);
    bit lock_pre;
    bit running;
    int p;
    edge_n++;
    lock_pre = (hist[1] != 0);
    running  = m_ready && lock_pre;
    streak   = lock_pre ? streak + 1 : 0;
    m_ready  = lock_pre && (streak >= LF + 1);
    for (int i = 0; i < NUM_CH; i++) begin
      p = (m_div[i] == 0) ? 1 : m_div[i];
      if (!running || rs || (we && ch == i)) begin
        origin[i] = edge_n;
        m_tick[i] = 1'b0;
      end else begin
        m_tick[i] = ((edge_n - origin[i]) % p) == 0;
      end
    end
    if (we && ch < NUM_CH) m_div[ch] = dv;
    hist[1] = hist[0];
    hist[0] = pl ? 1 : 0;
  endfunction

  function automatic logic [31:0] model_ticks();
    logic [31:0] v = 32'd0;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_tick[i];
    return v;
  endfunction

  // One clock: drive at negedge, let the posedge happen, compare at the next negedge
  task automatic step(input bit pl, input bit we, input int ch, input int dv, input bit rs);
    pll_locked = pl;
    cfg_we     = we;
    cfg_ch     = CH_W'(ch);
    cfg_div    = DIV_W'(dv);
    resync     = rs;
    model_edge(pl, we, ch, dv, rs);
    @(negedge clk);
    check_val("ready", {31'd0, ready}, {31'd0, m_ready});
    check_val("tick", {28'd0, tick}, model_ticks());
  endtask

  task automatic idle(input int n, input bit pl);
    for (int k = 0; k < n; k++) step(pl, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_ready", {31'd0, ready}, 32'd0);
    check_val("rst_tick", {28'd0, tick}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rdy_at;
    int t0_at;
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_div    = '0;
    resync     = 1'b0;
    @(negedge clk);
    do_reset();

    // Defaults with lock held high: ready latency and first slow tick
    rdy_at = 0;
    t0_at  = 0;
    for (int k = 1; k <= 200; k++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0);
      if (ready && rdy_at == 0) rdy_at = k;
      if (tick[0] && t0_at == 0) t0_at = k;
    end
    check_val("rdy_latency", rdy_at, 32'd11);
    check_val("t0_first", t0_at, 32'd86);

    // Lock glitch during FILTER
    idle(4, 1'b0);
    idle(8, 1'b1);
    idle(1, 1'b0);
    idle(30, 1'b1);

    // Divisor rewrite, P=0, equal-period resync, resync with simultaneous write
    step(1'b1, 1'b1, 0, 10, 1'b0);
    idle(40, 1'b1);
    step(1'b1, 1'b1, 3, 0, 1'b0);
    idle(5, 1'b1);
    step(1'b1, 1'b1, 0, 6, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 1, 6, 1'b0);
    idle(4, 1'b1);
    step(1'b1, 1'b0, 0, 0, 1'b1);
    idle(20, 1'b1);
    step(1'b1, 1'b1, 1, 3, 1'b1);
    idle(10, 1'b1);

    // Lock loss and re-qualification with divisors retained
    idle(10, 1'b0);
    idle(40, 1'b1);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      bit pl = ($urandom_range(0, 63) != 0);
      bit we = ($urandom_range(0, 15) == 0);
      bit rs = ($urandom_range(0, 31) == 0);
      step(pl, we, int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 20)), rs);
    end

    // Reset mid-RUN restores defaults
    idle(20, 1'b1);
    @(posedge clk);
    #2;
    do_reset();
    idle(200, 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
